// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and requester ids for the BRAM port arbiter
package bram_arb_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/bram_port_arbiter_rsp_tag_pipe.sv
// rsp_tag_pipe: LATENCY-deep {valid, id} shift register tracking reads in flight
module rsp_tag_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_id,
  output logic o_valid,
  output logic o_id
);
  logic [LATENCY-1:0] r_v;
  logic [LATENCY-1:0] r_id;
  // shift tags one stage per cycle so each emerges as the RAM data appears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_id <= '0;
    end else begin
      r_v[0]  <= i_valid;
      r_id[0] <= i_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_v[i]  <= r_v[i-1];
        r_id[i] <= r_id[i-1];
      end
    end
  end
  assign o_valid = r_v[LATENCY-1];
  assign o_id    = r_id[LATENCY-1];
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one RAM port with init sweep and tagged read return
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  output logic                         init_done,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic                         req0_we,
  input  logic [$clog2(DEPTH)-1:0]     req0_addr,
  input  logic [DATA_WIDTH-1:0]        req0_wdata,
  output logic                         rsp0_valid,
  output logic [DATA_WIDTH-1:0]        rsp0_rdata,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic                         req1_we,
  input  logic [$clog2(DEPTH)-1:0]     req1_addr,
  input  logic [DATA_WIDTH-1:0]        req1_wdata,
  output logic                         rsp1_valid,
  output logic [DATA_WIDTH-1:0]        rsp1_rdata,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [$clog2(DEPTH)-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]        ram_din,
  input  logic [DATA_WIDTH-1:0]        ram_dout
);
  localparam int AW = $clog2(DEPTH);
  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ptr;
  logic          w_init, w_ok, w_g0, w_g1, w_xfer, w_wwe, w_tv, w_tid;
  assign w_init     = r_state == INIT;
  assign w_ok       = r_state == RUN && !flush;
  assign req0_ready = w_ok && (!req1_valid || r_ptr == REQ0);
  assign req1_ready = w_ok && (!req0_valid || r_ptr == REQ1);
  assign w_g0       = req0_valid && req0_ready;
  assign w_g1       = req1_valid && req1_ready;
  assign w_xfer     = w_g0 || w_g1;
  assign w_wwe      = w_g1 ? req1_we : req0_we;
  assign ram_en     = w_init || w_xfer;
  assign ram_we     = w_init || (w_xfer && w_wwe);
  assign ram_addr   = w_init ? r_cnt : w_g1 ? req1_addr : req0_addr;
  assign ram_din    = w_init ? INIT_VALUE : w_g1 ? req1_wdata : req0_wdata;
  assign init_done  = r_state == RUN;
  // sweep every entry after reset or flush, then arbitrate; pointer flips to the loser after each transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_ptr   <= REQ0;
    end else if (w_init) begin
      r_cnt   <= r_cnt == AW'(DEPTH - 1) ? '0 : r_cnt + AW'(1);
      r_state <= r_cnt == AW'(DEPTH - 1) ? RUN : INIT;
    end else begin
      r_state <= flush ? INIT : RUN;
      r_ptr   <= w_xfer ? (w_g1 ? REQ0 : REQ1) : r_ptr;
    end
  end
  rsp_tag_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_xfer && !w_wwe),
    .i_id    (w_g1),
    .o_valid (w_tv),
    .o_id    (w_tid)
  );
  assign rsp0_valid = w_tv && w_tid == REQ0;
  assign rsp1_valid = w_tv && w_tid == REQ1;
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_bram_port_arbiter;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int LAT = 2;
  localparam logic [DW-1:0] INITV = 32'h1234_5678;

  logic clk = 0, rst = 1, flush = 0;
  logic init_done;
  logic req0_valid = 0, req0_ready, req0_we = 0, rsp0_valid;
  logic [2:0] req0_addr = 0;
  logic [DW-1:0] req0_wdata = 0, rsp0_rdata;
  logic req1_valid = 0, req1_ready, req1_we = 0, rsp1_valid;
  logic [2:0] req1_addr = 0;
  logic [DW-1:0] req1_wdata = 0, rsp1_rdata;
  logic ram_en, ram_we;
  logic [2:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  bram_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_VALUE(INITV)) dut (
    .clk(clk), .rst(rst), .flush(flush), .init_done(init_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // RAM wrapper stand-in: read-first synchronous port with LAT-cycle output
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] st [LAT];
  always @(posedge clk) begin
    if (ram_en) begin
      st[0] <= ram[ram_addr];
      if (ram_we) ram[ram_addr] <= ram_din;
    end
    for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
  end
  assign ram_dout = st[LAT-1];

  // reference model
  typedef struct { int due; bit id; logic [DW-1:0] data; } rsp_t;
  rsp_t q[$];
  logic [DW-1:0] mem [DEPTH];
  int left, cyc;
  bit ptr;
  int total = 0, passed = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
  endtask

  task automatic model_reset();
    q.delete();
    left = DEPTH;
    ptr = 0;
  endtask

  task automatic step(input bit v0, input bit w0, input logic [2:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input bit w1, input logic [2:0] a1, input logic [DW-1:0] d1,
                      input bit fl, output int win);
    bit run, r0, r1;
    logic [DW-1:0] e0, e1;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    flush = fl;
    run = left == 0;
    win = -1;
    if (run && !fl) win = (v0 && v1) ? int'(ptr) : v0 ? 0 : v1 ? 1 : -1;
    @(negedge clk);
    chk("init_done", init_done, run);
    chk("grant0", req0_valid & req0_ready, win == 0);
    chk("grant1", req1_valid & req1_ready, win == 1);
    if (!run) begin
      chk("sweep_ready", {req0_ready, req1_ready}, 2'b00);
      chk("sweep_en_we", {ram_en, ram_we}, 2'b11);
      chk("sweep_addr", ram_addr, DEPTH - left);
      chk("sweep_din", ram_din, INITV);
    end else if (win < 0) begin
      chk("idle_en_we", {ram_en, ram_we}, 2'b00);
      if (fl) chk("flush_ready", {req0_ready, req1_ready}, 2'b00);
    end else begin
      chk("xfer_en", ram_en, 1);
      chk("xfer_we", ram_we, win ? w1 : w0);
      chk("xfer_addr", ram_addr, win ? a1 : a0);
      chk("xfer_din", ram_din, win ? d1 : d0);
    end
    r0 = 0; r1 = 0; e0 = 0; e1 = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].id) begin r1 = 1; e1 = q[0].data; end
      else begin r0 = 1; e0 = q[0].data; end
    end
    chk("rsp0_valid", rsp0_valid, r0);
    chk("rsp1_valid", rsp1_valid, r1);
    chk("rsp0_rdata", rsp0_rdata, e0);
    chk("rsp1_rdata", rsp1_rdata, e1);
    @(posedge clk);
    if (r0 || r1) void'(q.pop_front());
    if (!run) begin
      mem[DEPTH - left] = INITV;
      left--;
    end else if (fl) begin
      left = DEPTH;
    end else if (win >= 0) begin
      if (win ? w1 : w0) mem[win ? a1 : a0] = win ? d1 : d0;
      else q.push_back('{cyc + LAT, bit'(win), mem[win ? a1 : a0]});
      ptr = !bit'(win);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
  endtask

  task automatic rand_steps(input int n, input int flush_odds);
    int w;
    for (int i = 0; i < n; i++)
      step($urandom_range(1, 0), $urandom_range(1, 0), 3'($urandom), $urandom,
           $urandom_range(1, 0), $urandom_range(1, 0), 3'($urandom), $urandom,
           flush_odds > 0 && $urandom_range(flush_odds - 1, 0) == 0, w);
  endtask

  task automatic do_reset();
    #2;
    req0_valid = 1; req1_valid = 1;
    rst = 1;
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    bit v0, w0; logic [2:0] a0; logic [DW-1:0] d0;
    bit v1, w1; logic [2:0] a1; logic [DW-1:0] d1;
    bit fl; int win;
  } vec_t;
  vec_t vt[13];

  initial begin
    int w;
    cyc = 0;
    model_reset();
    @(negedge clk);
    chk("por_init_done", init_done, 0);
    chk("por_ready", {req0_ready, req1_ready}, 2'b00);
    chk("por_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
    @(posedge clk);
    #1;
    rst = 0;
    rand_steps(DEPTH, 0);
    vt[0]  = '{1, 0, 3, 0, 1, 0, 5, 0, 0, 0};
    vt[1]  = '{1, 0, 3, 0, 1, 0, 5, 0, 0, 1};
    vt[2]  = '{1, 0, 3, 0, 1, 0, 5, 0, 0, 0};
    vt[3]  = '{1, 0, 3, 0, 1, 0, 5, 0, 0, 1};
    vt[4]  = '{1, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 1, 0, 2, 0, 0, 1};
    vt[6]  = '{0, 0, 0, 0, 1, 0, 6, 0, 0, 1};
    vt[7]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 0, 1, 0, 4, 0, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    vt[10] = '{1, 1, 3, 32'hCAFE0003, 0, 0, 0, 0, 0, 0};
    vt[11] = '{1, 0, 3, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{1, 0, 5, 0, 1, 0, 5, 0, 1, -1};
    for (int i = 0; i < 13; i++) begin
      step(vt[i].v0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].fl, w);
      chk($sformatf("vec%0d_winner", i), 32'(w), 32'(vt[i].win));
    end
    rand_steps(DEPTH, 0);
    for (int a = 0; a < DEPTH; a++) step(1, 0, 3'(a), 0, 0, 0, 0, 0, 0, w);
    idle(LAT);
    rand_steps(400, 40);
    while (left != 0) rand_steps(1, 0);
    step(1, 0, 3'd2, 0, 0, 0, 0, 0, 0, w);
    do_reset();
    idle(4);
    chk("sweep_at_4", ram_addr, 4);
    do_reset();
    idle(DEPTH);
    idle(LAT + 1);
    rand_steps(100, 30);
    idle(DEPTH + LAT);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
